// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift the remainder left, pull in the
// next dividend bit, keep the difference only if it did not underflow.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_r,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  assign w_shifted = {i_r, i_q_msb};
  assign w_diff    = w_shifted - {2'b00, i_divisor};
  // Working remainder stays below the divisor, so the top diff bit is the sign.
  assign w_borrow  = w_diff[WIDTH+1];
  assign o_r       = w_borrow ? w_shifted[WIDTH:0] : w_diff[WIDTH:0];
  assign o_q_bit   = ~w_borrow;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional signed operation is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd;
  logic             r_zero;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
`else
  assign w_dvd_neg = 1'b0;
  assign w_dvs_neg = 1'b0;
`endif

  assign w_dvd_mag = w_dvd_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? ({WIDTH{1'b0}} - divisor) : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r       (r_rem),
    .i_q_msb   (r_q[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_r       (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  assign w_q_fin = {r_q[WIDTH-2:0], w_q_bit};
  assign w_r_fin = w_r_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_next = DONE;
        end else begin
          w_state_next = CALC;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A zero divisor runs a single dummy CALC cycle so done lands one edge after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= {CW{1'b0}};
      r_rem   <= {(WIDTH+1){1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_dvs   <= {WIDTH{1'b0}};
      r_dvd   <= {WIDTH{1'b0}};
      r_zero  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= {WIDTH{1'b0}};
      r_remo  <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_zero  <= (divisor == {WIDTH{1'b0}});
            r_dvs   <= w_dvs_mag;
            r_dvd   <= dividend;
            r_q     <= w_dvd_mag;
            r_rem   <= {(WIDTH+1){1'b0}};
            r_cnt   <= (divisor == {WIDTH{1'b0}}) ? {CW{1'b0}} : CW'(WIDTH - 1);
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
          end else begin
            r_busy <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_r_next;
          r_q   <= w_q_fin;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == {CW{1'b0}}) begin
            r_done <= 1'b1;
            if (r_zero) begin
              r_quot <= {WIDTH{1'b1}};
              r_remo <= r_dvd;
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= r_neg_q ? ({WIDTH{1'b0}} - w_q_fin) : w_q_fin;
              r_remo <= r_neg_r ? ({WIDTH{1'b0}} - w_r_fin) : w_r_fin;
              r_dbz  <= 1'b0;
            end
          end else begin
            r_done <= 1'b0;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign result      = {r_remo, r_quot};
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=16); signed vectors
// run only when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  dividend = 16'h0000;
  logic [W-1:0]  divisor = 16'h0000;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic [2*W-1:0] result;
  logic          div_by_zero;

  int total = 0;
  int bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Launch one divide and follow it to done; optional start pulses mid-run
  // and a hold check on the previous quotient while CALC is active.
  task automatic do_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic sgn, input int exp_lat, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edbz, input logic noise,
                        input logic hold, input logic [W-1:0] hq);
    int lat;
    int busy_low;
    int dones;
    @(posedge clk); #1;
    dividend = dvd; divisor = dvs; is_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'hA5A5; divisor = 16'h5A5A; is_signed = ~sgn;
    lat = 0; busy_low = 0;
    while (lat < 40) begin
      if (!busy) busy_low++;
      if (done) break;
      if (hold && lat == 5) chk({tag, "_hold"}, {16'h0000, quotient}, {16'h0000, hq});
      if (noise && (lat == 3 || lat == 10)) begin
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_quot"}, {16'h0000, quotient}, {16'h0000, eq});
    chk({tag, "_rem"}, {16'h0000, remainder}, {16'h0000, er});
    chk({tag, "_result"}, result, {er, eq});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    chk({tag, "_busy_gap"}, busy_low, 32'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (i == 0) chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    end
    chk({tag, "_extra_done"}, dones, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'h0000_0000);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    do_div("d100_7", 16'd100, 16'd7, 1'b0, 16, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_div("dffff_1", 16'hFFFF, 16'd1, 1'b0, 16, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_div("d5_9", 16'd5, 16'd9, 1'b0, 16, 16'h0000, 16'd5, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    do_div("dzero", 16'h1234, 16'h0000, 1'b0, 1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_div("after_zero", 16'd1000, 16'd10, 1'b0, 16, 16'd100, 16'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_div("noise", 16'd200, 16'd3, 1'b0, 16, 16'd66, 16'd2, 1'b0, 1'b1, 1'b0, 16'h0000);

    // Reset in the middle of CALC aborts without a done pulse.
    @(posedge clk); #1;
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'h0000_0000);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    do_div("post_abort", 16'd50, 16'd6, 1'b0, 16, 16'd8, 16'd2, 1'b0, 1'b0, 1'b0, 16'h0000);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div("s_m7_2", 16'hFFF9, 16'd2, 1'b1, 16, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_div("s_min_m1", 16'h8000, 16'hFFFF, 1'b1, 16, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_div("u_fff9_2", 16'hFFF9, 16'd2, 1'b0, 16, 16'h7FFC, 16'd1, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_div("s_zero", 16'hFFF9, 16'h0000, 1'b1, 1, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0, 1'b0, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
